// File: rtl/dffre_pipe_pkg.sv
// dffre_pipe_pkg: shared helpers for the dffre_pipe register chain.
package dffre_pipe_pkg;

  // Width of the occupancy count: enough bits to hold 0..depth, never below 1.
  function automatic int occ_width(input int depth);
    int w;
    w = $clog2(depth + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/dffre_pipe_if.sv
// dffre_pipe_if: upstream/downstream valid-ready bus of the dffre_pipe chain.
// master drives data into the pipe and consumes Q; slave is the pipe itself.
interface dffre_pipe_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] D;
  logic             D_VALID;
  logic             D_READY;
  logic [WIDTH-1:0] Q;
  logic             Q_VALID;
  logic             Q_READY;

  modport master (
    output D, D_VALID, Q_READY,
    input  D_READY, Q, Q_VALID
  );

  modport slave (
    input  D, D_VALID, Q_READY,
    output D_READY, Q, Q_VALID
  );
endinterface

// File: rtl/dffre_pipe_stage.sv
// dffre_pipe_stage: one data/valid register of the chain with synchronous
// reset, global enable and a collapsing ready term (an empty stage always
// accepts, a full one only when the stage ahead is taking its word).
module dffre_pipe_stage #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_vld,
  input  logic             nxt_rdy,
  output logic [WIDTH-1:0] data,
  output logic             vld,
  output logic             rdy
);

  assign rdy = en & (~vld | nxt_rdy);

  // Load the upstream word (or a bubble) whenever this stage is ready; bubbles keep the old data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld  <= 1'b0;
      data <= INIT_VALUE;
    end else if (rdy) begin
      vld <= in_vld;
      if (in_vld) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/dffre_pipe.sv
// dffre_pipe: WIDTH-bit, DEPTH-stage enable-gated register chain with
// valid/ready flow control and bubble collapsing. Optional occupancy count
// output OCC is built only when DFFRE_PIPE_OCC_EN is defined.
module dffre_pipe
  import dffre_pipe_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter int               DEPTH      = 3,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic               C,
  input  logic               R,
  input  logic               E,
  dffre_pipe_if.slave        bus
`ifdef DFFRE_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] OCC
`endif
);

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] in_data;
    logic             in_vld;
    logic             nxt_rdy;
    logic [WIDTH-1:0] data;
    logic             vld;
    logic             rdy;

    if (i == 0) begin : g_head
      assign in_data = bus.D;
      assign in_vld  = bus.D_VALID;
    end else begin : g_body
      assign in_data = g_stage[i-1].data;
      assign in_vld  = g_stage[i-1].vld;
    end

    if (i == DEPTH - 1) begin : g_tail
      assign nxt_rdy = bus.Q_READY & E;
    end else begin : g_mid
      assign nxt_rdy = g_stage[i+1].rdy;
    end

    dffre_pipe_stage #(
      .WIDTH      (WIDTH),
      .INIT_VALUE (INIT_VALUE)
    ) u_stage (
      .clk     (C),
      .rst     (R),
      .en      (E),
      .in_data (in_data),
      .in_vld  (in_vld),
      .nxt_rdy (nxt_rdy),
      .data    (data),
      .vld     (vld),
      .rdy     (rdy)
    );
  end

  assign bus.D_READY = g_stage[0].rdy;
  assign bus.Q       = g_stage[DEPTH-1].data;
  assign bus.Q_VALID = g_stage[DEPTH-1].vld & E;

`ifdef DFFRE_PIPE_OCC_EN
  localparam int OW = occ_width(DEPTH);

  logic          in_xfer;
  logic          out_xfer;
  logic [OW-1:0] occ_q;

  assign in_xfer  = bus.D_VALID & bus.D_READY;
  assign out_xfer = bus.Q_VALID & bus.Q_READY;
  assign OCC      = occ_q;

  // Track resident words: +1 on accept-only, -1 on emit-only, clamped to 0..DEPTH.
  always_ff @(posedge C) begin
    if (R) begin
      occ_q <= '0;
    end else if (in_xfer && !out_xfer && occ_q != OW'(DEPTH)) begin
      occ_q <= occ_q + 1'b1;
    end else if (out_xfer && !in_xfer && occ_q != '0) begin
      occ_q <= occ_q - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dffre_pipe.sv
// tb_dffre_pipe: directed scenarios plus a random phase for dffre_pipe,
// checked against a word-position reference model.
module tb_dffre_pipe;
  import dffre_pipe_pkg::*;

  localparam int         W     = 8;
  localparam int         DEPTH = 3;
  localparam logic [7:0] INIT  = 8'hA5;

  logic C = 1'b0;
  logic R = 1'b1;
  logic E = 1'b1;

  dffre_pipe_if #(.WIDTH(W)) bus ();

`ifdef DFFRE_PIPE_OCC_EN
  logic [occ_width(DEPTH)-1:0] OCC;
`endif

  dffre_pipe #(
    .WIDTH      (W),
    .DEPTH      (DEPTH),
    .INIT_VALUE (INIT)
  ) dut (
    .C   (C),
    .R   (R),
    .E   (E),
    .bus (bus)
`ifdef DFFRE_PIPE_OCC_EN
    ,
    .OCC (OCC)
`endif
  );

  always #5 C = ~C;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  word_t      wq[$];
  logic [7:0] last_q;
  int         obs_log[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  logic       obs_dr, obs_qv;
  logic [7:0] obs_q;
  int         obs_occ;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_log(input string tag, input int exp[$]);
    chk({tag, "_count"}, obs_log.size(), exp.size());
    for (int k = 0; k < exp.size() && k < obs_log.size(); k++)
      chk({tag, "_word"}, obs_log[k], exp[k]);
    obs_log.delete();
  endtask

  // Reference: each resident word has a position 0..DEPTH-1; a word moves
  // forward whenever the slot ahead is free after the words in front moved.
  task automatic model_edge(input bit e, input bit dv, input logic [7:0] d,
                            input bit qr, input bit r);
    word_t nq[$];
    word_t w;
    int    limit;
    int    np;
    bit    acc;
    if (r) begin
      wq.delete();
      last_q = INIT;
    end else if (e) begin
      acc   = dv && (wq.size() < DEPTH || qr);
      limit = DEPTH;
      foreach (wq[k]) begin
        w = wq[k];
        if (w.pos == DEPTH - 1) begin
          if (!qr) begin
            nq.push_back(w);
            limit = DEPTH - 1;
          end
        end else begin
          np = (w.pos + 1 < limit) ? w.pos + 1 : w.pos;
          if (np == DEPTH - 1 && np != w.pos) last_q = w.data;
          w.pos = np;
          nq.push_back(w);
          limit = np;
        end
      end
      if (acc) begin
        w.data = d;
        w.pos  = 0;
        if (DEPTH == 1) last_q = d;
        nq.push_back(w);
      end
      wq = nq;
    end
  endtask

  // One clock cycle: drive, check settled outputs against the model, clock, update model.
  task automatic step(input bit e, input bit dv, input logic [7:0] d,
                      input bit qr, input bit r, input bit chk_en);
    bit exp_dr, exp_qv;
    E = e; bus.D_VALID = dv; bus.D = d; bus.Q_READY = qr; R = r;
    #1;
    obs_dr = bus.D_READY;
    obs_qv = bus.Q_VALID;
    obs_q  = bus.Q;
`ifdef DFFRE_PIPE_OCC_EN
    obs_occ = int'(OCC);
`else
    obs_occ = wq.size();
`endif
    exp_dr = e && (wq.size() < DEPTH || qr);
    exp_qv = e && wq.size() > 0 && wq[0].pos == DEPTH - 1;
    if (chk_en) begin
      chk("d_ready", obs_dr, exp_dr);
      chk("q_valid", obs_qv, exp_qv);
      chk("q_data", obs_q, last_q);
`ifdef DFFRE_PIPE_OCC_EN
      chk("occ", obs_occ, wq.size());
`endif
    end
    if (!r && obs_qv && qr) obs_log.push_back(int'(obs_q));
    @(posedge C);
    model_edge(e, dv, d, qr, r);
    @(negedge C);
  endtask

  task automatic drain();
    for (int k = 0; k < DEPTH + 2; k++) step(1, 0, 8'h00, 1, 0, 1);
  endtask

  initial begin
    int         nxt;
    int         sent;
    int         exp_words[$];
    logic [7:0] rd;
    bus.D = '0; bus.D_VALID = 1'b0; bus.Q_READY = 1'b0;
    last_q = INIT;

    // 1. Reset
    step(1, 0, 8'h00, 0, 1, 0);
    step(1, 0, 8'h00, 0, 1, 0);
    E = 1; R = 0; #1;
    chk("rst_q", bus.Q, 8'hA5);
    chk("rst_qv", bus.Q_VALID, 1'b0);
    chk("rst_dr", bus.D_READY, 1'b1);
`ifdef DFFRE_PIPE_OCC_EN
    chk("rst_occ", OCC, 0);
`endif

    // 2. Streaming
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 8'(i + 1), 1, 0, 1);
      chk("stream_dr", obs_dr, 1'b1);
      chk("stream_qv", obs_qv, i >= DEPTH);
      if (i >= DEPTH) chk("stream_q", obs_q, 8'(i - DEPTH + 1));
    end
    drain();
    exp_words.delete();
    for (int k = 1; k <= 10; k++) exp_words.push_back(k);
    chk_log("stream_order", exp_words);

    // 3. Backpressure
    nxt = 1;
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 8'(nxt), 0, 0, 1);
      if (i < 3) chk("bp_dr_accept", obs_dr, 1'b1);
      else begin
        chk("bp_dr_full", obs_dr, 1'b0);
        chk("bp_occ_full", obs_occ, 3);
      end
      if (obs_dr) nxt++;
    end
    for (int i = 0; i < 20 && nxt <= 5; i++) begin
      step(1, 1, 8'(nxt), 1, 0, 1);
      if (obs_dr) nxt++;
    end
    drain();
    exp_words = '{1, 2, 3, 4, 5};
    chk_log("bp_order", exp_words);

    // 4. Enable freeze
    step(1, 1, 8'd7, 0, 0, 1);
    step(1, 1, 8'd8, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 8'd9, 1, 0, 1);
      chk("frz_dr", obs_dr, 1'b0);
      chk("frz_qv", obs_qv, 1'b0);
      chk("frz_occ", obs_occ, 2);
    end
    drain();
    exp_words = '{7, 8};
    chk_log("frz_order", exp_words);

    // 5. Bubble collapse
    step(1, 1, 8'd1, 0, 0, 1);
    step(1, 0, 8'd0, 0, 0, 1);
    step(1, 0, 8'd0, 0, 0, 1);
    step(1, 1, 8'd2, 0, 0, 1);
    chk("bub_dr", obs_dr, 1'b1);
    step(1, 0, 8'd0, 0, 0, 1);
    chk("bub_occ", obs_occ, 2);
    drain();
    exp_words = '{1, 2};
    chk_log("bub_order", exp_words);

    // 6. Mid-stream reset
    for (int i = 0; i < 4; i++) step(1, 1, 8'(8'h10 + i), 0, 0, 1);
    step(1, 0, 8'h00, 0, 1, 0);
    E = 1; R = 0; bus.Q_READY = 1; bus.D_VALID = 0; #1;
    chk("mrst_qv", bus.Q_VALID, 1'b0);
    chk("mrst_q", bus.Q, 8'hA5);
    chk("mrst_dr", bus.D_READY, 1'b1);
`ifdef DFFRE_PIPE_OCC_EN
    chk("mrst_occ", OCC, 0);
`endif
    step(1, 1, 8'h42, 1, 0, 1);
    for (int i = 1; i <= 5; i++) begin
      step(1, 0, 8'h00, 1, 0, 1);
      chk("mrst_lat_qv", obs_qv, i == DEPTH);
    end
    exp_words = '{8'h42};
    chk_log("mrst_order", exp_words);

    // Random phase
    obs_log.delete();
    exp_words.delete();
    sent = 0;
    rd   = 8'($urandom);
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, rd,
           $urandom_range(0, 2) != 0, 0, 1);
      if (E && bus.D_VALID && obs_dr) begin
        exp_words.push_back(int'(rd));
        sent++;
        rd = 8'($urandom);
      end
    end
    drain();
    chk_log("rand_order", exp_words);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/dffre_pipe.md
Name: dffre_pipe

Overview:
Parametrised multi-bit, multi-stage register chain built from enable-gated flops with synchronous reset. Carries a valid/ready handshake with bubble collapsing. Used wherever fabric logic needs DEPTH cycles of retiming on a WIDTH-bit bus with backpressure. Successor of the single-bit enable flop primitive: adds width, depth, a configurable reset value and flow control.

Parameters:
WIDTH, 8, data bus width in bits (>=1)
DEPTH, 3, number of register stages (>=1); latency in cycles with no stalls
INIT_VALUE, {WIDTH{1'b0}}, value loaded into every stage's data register on reset

Ports:
C  input  1  clock; all state updates on posedge C
R  input  1  reset, synchronous, active-high
E  input  1  global enable, active-high; E=0 freezes all state
D  input  WIDTH  upstream data
D_VALID  input  1  upstream data valid
D_READY  output  1  block can accept D this cycle
Q  output  WIDTH  downstream data (last stage)
Q_VALID  output  1  Q holds valid data
Q_READY  input  1  downstream accepts Q this cycle
OCC  output  $clog2(DEPTH+1)  occupied stage count (only with DFFRE_PIPE_OCC_EN)

Behaviour:
- Reset is synchronous and active-high on R. Clock port C, reset port R.
- State per stage i (0..DEPTH-1): data_i[WIDTH], v_i.
- R=1 at posedge C: all v_i<=0, all data_i<=INIT_VALUE, OCC<=0. R has priority over E and over any handshake.
- Outputs after reset: Q=INIT_VALUE, Q_VALID=0, D_READY=E.
- Ready chain (combinational): rdy_DEPTH = Q_READY & E; rdy_i = E & (!v_i | rdy_{i+1}). D_READY = rdy_0.
- Stage i loads when rdy_i=1: data_i <= (i==0 ? D : data_{i-1}) only if the incoming valid is 1; v_i <= incoming valid (D_VALID for stage 0, v_{i-1} otherwise). A bubble clears v_i and leaves data_i unchanged.
- When rdy_i=0, the stage holds data_i and v_i.
- Q = data_{DEPTH-1}. Q_VALID = v_{DEPTH-1} & E. Transfers require E=1 on both sides.
- Input transfer: D_VALID & D_READY. Output transfer: Q_VALID & Q_READY.
- Latency: a word accepted at edge n appears with Q_VALID=1 after edge n+DEPTH-1, i.e. DEPTH register stages, provided there are no stalls.
- Throughput: 1 word/cycle while Q_READY=1.
- Bubbles collapse. An empty stage accepts even if downstream is stalled, so a stalled pipe fills to DEPTH words before D_READY drops.
- Full (all v_i=1) with Q_READY=0: D_READY=0. Nothing is lost or overwritten.
- Full with Q_READY=1: accept and emit in the same cycle; occupancy stays DEPTH.
- E=0: no state changes, D_READY=0, Q_VALID=0. Data is retained and reappears when E returns to 1.
- R asserted mid-stream: in-flight words are discarded. D_READY is valid again the next cycle if E=1.
- Ordering strictly FIFO. No duplication or loss.

Optional Feature:
Macro DFFRE_PIPE_OCC_EN.
- Defined: OCC port exists. OCC is a registered count of v_i. It increments on input-only transfer, decrements on output-only transfer, and is unchanged on both or neither. It resets to 0 and saturates within 0..DEPTH; a value outside that range is a design error.
- Undefined: OCC port and counter are absent. All other behaviour is identical.

Decomposition:
- Package dffre_pipe_pkg: function occ_width(depth) returning $clog2(depth+1), with minimum 1.
- Sub-module dffre_pipe_stage: one data/valid stage with sync reset, E gating and ready computation. The top generates DEPTH instances.

Test Plan:
1. Reset: WIDTH=8, DEPTH=3, INIT_VALUE=8'hA5, R=1 for 2 cycles -> Q=8'hA5, Q_VALID=0, OCC=0; after R drops, D_READY=1.
2. Streaming: D_VALID=1, D=1,2,3,4..., Q_READY=1 -> Q_VALID first high 3 cycles after the first accept; Q sequence 1,2,3,4 with no gaps.
3. Backpressure: Q_READY=0, push 5 words -> 3 words accepted, D_READY=0 on the 4th, OCC=3; Q_READY=1 -> outputs 1,2,3, then 4,5 follow in order.
4. Enable freeze: pipe holding 7,8 and E=0 for 4 cycles with D_VALID=1 -> D_READY=0, Q_VALID=0, OCC constant; E=1 -> 7,8 emerge unchanged.
5. Bubble collapse: send 1, idle 2 cycles, send 2 while Q_READY=0 -> both resident, OCC=2, and 2 is accepted without waiting on downstream.
6. Mid-stream reset: full pipe with R=1 for one cycle -> next cycle Q_VALID=0, OCC=0, Q=INIT_VALUE; a new word after reset emerges alone after 3 cycles.
